// File: rtl/weight_feed_scheduler_pkg.sv
// Shared definitions for the weight feed scheduler: state codes, config word
// field layout and the default lane count.
package weight_feed_scheduler_pkg;

    localparam int unsigned WSCHED_LANES = 64;

    localparam int unsigned TILE_CNT_LSB = 0;
    localparam int unsigned TILE_CNT_MSB = 23;
    localparam int unsigned BURST_LSB    = 24;
    localparam int unsigned BURST_MSB    = 31;
    localparam int unsigned TILE_CNT_W   = TILE_CNT_MSB - TILE_CNT_LSB + 1;
    localparam int unsigned BURST_W      = BURST_MSB - BURST_LSB + 1;

    typedef enum logic [3:0] {
        WS_IDLE  = 4'd1,
        WS_WAIT  = 4'd2,
        WS_ISSUE = 4'd3,
        WS_DRAIN = 4'd4,
        WS_DONE  = 4'd5
    } wsched_state_e;

    // The config field holds burst_len-1, so a burst spans 1..256 reads.
    function automatic logic [BURST_W:0] burst_len_of(input logic [BURST_W-1:0] field);
        return {1'b0, field} + 1'b1;
    endfunction

endpackage

// File: rtl/weight_feed_scheduler_skew_chain.sv
// Diagonal skew chain: lane i sees the lane-0 read enable and end-of-burst
// marker delayed by i*SKEW cycles; busy_o is high while anything is in flight.
module weight_skew_chain
    import weight_feed_scheduler_pkg::*;
#(
    parameter int unsigned LANES = WSCHED_LANES,
    parameter int unsigned SKEW  = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             rd0_i,
    input  logic             end0_i,
    output logic [LANES-1:0] rd_en_o,
    output logic             tile_end_o,
    output logic             busy_o
);

    localparam int unsigned DEPTH = (LANES - 1) * SKEW;

    logic [DEPTH:1] rd_q;
    logic [DEPTH:1] end_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_q  <= '0;
            end_q <= '0;
        end else begin
            rd_q[1]  <= rd0_i;
            end_q[1] <= end0_i;
            for (int unsigned k = 2; k <= DEPTH; k++) begin
                rd_q[k]  <= rd_q[k-1];
                end_q[k] <= end_q[k-1];
            end
        end
    end

    always_comb begin
        rd_en_o    = '0;
        rd_en_o[0] = rd0_i;
        for (int unsigned i = 1; i < LANES; i++) begin
            rd_en_o[i] = rd_q[i*SKEW];
        end
    end

    // Only the last lane's marker is consumed; it becomes tile_done.
    assign tile_end_o = end_q[DEPTH];
    assign busy_o     = |rd_q;

endmodule

// File: rtl/weight_feed_scheduler.sv
// Weight feed scheduler: bursts lane-0 reads per tile, gated on FIFO fill and
// array readiness. WEIGHT_SKEW_EN enables the diagonal per-lane skew chain.
module weight_feed_scheduler
    import weight_feed_scheduler_pkg::*;
#(
    parameter int unsigned LANES  = WSCHED_LANES,
`ifdef WEIGHT_SKEW_EN
    parameter int unsigned SKEW   = 1,
`endif
    parameter int unsigned DCNT_W = 10
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              s_config_valid,
    output logic              s_config_ready,
    input  logic [31:0]       s_config_data,
    input  logic [LANES-1:0]  weight_valid,
    input  logic [DCNT_W-1:0] weight_dcnt,
    input  logic              array_ready,
    output logic [LANES-1:0]  m_weight_ready,
    output logic              tile_start,
    output logic              tile_done,
    output logic              sched_done,
    output logic              underflow_err,
    output logic [3:0]        status_wsched
);

    wsched_state_e           state_q;
    logic [TILE_CNT_W-1:0]   tile_cnt_q;
    logic [TILE_CNT_W-1:0]   tiles_issued_q;
    logic [BURST_W-1:0]      burst_m1_q;
    logic [BURST_W-1:0]      burst_cnt_q;
    logic                    wait_first_q;
    logic                    rd0_q;
    logic                    end0_q;
    logic                    tile_start_q;
    logic                    sched_done_q;
    logic                    underflow_q;

    logic                    cfg_accept;
    logic                    fill_ok;
    logic                    underflow_d;
    logic                    chain_busy;

    assign s_config_ready = (state_q == WS_IDLE) && !rst;
    assign cfg_accept     = s_config_valid && s_config_ready;
    assign fill_ok        = 32'(weight_dcnt) >= 32'(burst_len_of(burst_m1_q));
    assign underflow_d    = |(m_weight_ready & ~weight_valid);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= WS_IDLE;
            tile_cnt_q     <= '0;
            tiles_issued_q <= '0;
            burst_m1_q     <= '0;
            burst_cnt_q    <= '0;
            wait_first_q   <= 1'b0;
            rd0_q          <= 1'b0;
            end0_q         <= 1'b0;
            tile_start_q   <= 1'b0;
            sched_done_q   <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            tile_start_q <= 1'b0;
            sched_done_q <= 1'b0;
            end0_q       <= 1'b0;
            if (underflow_d) begin
                underflow_q <= 1'b1;
            end

            case (state_q)
                WS_IDLE: begin
                    if (cfg_accept) begin
                        tile_cnt_q     <= s_config_data[TILE_CNT_MSB:TILE_CNT_LSB];
                        burst_m1_q     <= s_config_data[BURST_MSB:BURST_LSB];
                        tiles_issued_q <= '0;
                        underflow_q    <= 1'b0;
                        wait_first_q   <= 1'b1;
                        state_q        <= (s_config_data[TILE_CNT_MSB:TILE_CNT_LSB] == '0)
                                          ? WS_DONE : WS_WAIT;
                    end
                end

                // First WAIT cycle ignores the fill count, which lags by one cycle.
                WS_WAIT: begin
                    if (wait_first_q) begin
                        wait_first_q <= 1'b0;
                    end else if (fill_ok && array_ready) begin
                        state_q      <= WS_ISSUE;
                        rd0_q        <= 1'b1;
                        tile_start_q <= 1'b1;
                        burst_cnt_q  <= burst_m1_q;
                        end0_q       <= (burst_m1_q == '0);
                    end
                end

                // end0_q is raised one cycle ahead so it lines up with the last read.
                WS_ISSUE: begin
                    if (burst_cnt_q == '0) begin
                        rd0_q          <= 1'b0;
                        tiles_issued_q <= tiles_issued_q + 1'b1;
                        if (tiles_issued_q + 1'b1 == tile_cnt_q) begin
                            state_q <= WS_DRAIN;
                        end else begin
                            state_q      <= WS_WAIT;
                            wait_first_q <= 1'b1;
                        end
                    end else begin
                        burst_cnt_q <= burst_cnt_q - 1'b1;
                        end0_q      <= (burst_cnt_q == BURST_W'(1));
                    end
                end

                WS_DRAIN: begin
                    if (!chain_busy) begin
                        state_q <= WS_DONE;
                    end
                end

                WS_DONE: begin
                    sched_done_q <= 1'b1;
                    state_q      <= WS_IDLE;
                end

                default: begin
                    state_q <= WS_IDLE;
                end
            endcase
        end
    end

`ifdef WEIGHT_SKEW_EN
    weight_skew_chain #(
        .LANES (LANES),
        .SKEW  (SKEW)
    ) u_skew_chain (
        .clk_i      (clk),
        .rst_i      (rst),
        .rd0_i      (rd0_q),
        .end0_i     (end0_q),
        .rd_en_o    (m_weight_ready),
        .tile_end_o (tile_done),
        .busy_o     (chain_busy)
    );
`else
    assign m_weight_ready = {LANES{rd0_q}};
    assign tile_done      = end0_q;
    assign chain_busy     = 1'b0;
`endif

    assign tile_start    = tile_start_q;
    assign sched_done    = sched_done_q;
    assign underflow_err = underflow_q;
    assign status_wsched = state_q;

endmodule

// File: tb/tb_weight_feed_scheduler.sv
// Self-checking bench for weight_feed_scheduler; expected waveforms come from a
// tile/burst timetable model. Follows WEIGHT_SKEW_EN to choose the lane skew.
module tb_weight_feed_scheduler;

    localparam int LANES  = 64;
    localparam int DCNT_W = 10;
`ifdef WEIGHT_SKEW_EN
    localparam int S = 1;
`else
    localparam int S = 0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              s_config_valid;
    logic              s_config_ready;
    logic [31:0]       s_config_data;
    logic [LANES-1:0]  weight_valid;
    logic [DCNT_W-1:0] weight_dcnt;
    logic              array_ready;
    logic [LANES-1:0]  m_weight_ready;
    logic              tile_start;
    logic              tile_done;
    logic              sched_done;
    logic              underflow_err;
    logic [3:0]        status_wsched;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    weight_feed_scheduler dut (
        .clk            (clk),
        .rst            (rst),
        .s_config_valid (s_config_valid),
        .s_config_ready (s_config_ready),
        .s_config_data  (s_config_data),
        .weight_valid   (weight_valid),
        .weight_dcnt    (weight_dcnt),
        .array_ready    (array_ready),
        .m_weight_ready (m_weight_ready),
        .tile_start     (tile_start),
        .tile_done      (tile_done),
        .sched_done     (sched_done),
        .underflow_err  (underflow_err),
        .status_wsched  (status_wsched)
    );

    // Timetable model: with the gates open, tile k's lane-0 burst starts at
    // cycle 3 + k*(b+2) after the accept edge; lane i runs i*S cycles later.
    function automatic int burst_start(int k, int b);
        return 3 + k * (b + 2);
    endfunction

    function automatic logic [LANES-1:0] exp_lanes(int n, int b, int t);
        logic [LANES-1:0] v;
        int d;
        v = '0;
        for (int i = 0; i < LANES; i++) begin
            d = n - i * S;
            for (int k = 0; k < t; k++) begin
                if (d >= burst_start(k, b) && d < burst_start(k, b) + b) v[i] = 1'b1;
            end
        end
        return v;
    endfunction

    function automatic logic exp_start(int n, int b, int t);
        for (int k = 0; k < t; k++) if (n == burst_start(k, b)) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic exp_done(int n, int b, int t);
        for (int k = 0; k < t; k++)
            if (n == burst_start(k, b) + b - 1 + (LANES - 1) * S) return 1'b1;
        return 1'b0;
    endfunction

    // Leaves the bench at the sample point of cycle 1 after the accept edge.
    task automatic send_cfg(input logic [31:0] word);
        int w;
        w = 0;
        while (s_config_ready !== 1'b1 && w < 500) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (s_config_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL cfg_ready_timeout got=%b exp=1", s_config_ready);
        end
        s_config_valid = 1'b1;
        s_config_data  = word;
        @(negedge clk);
        s_config_valid = 1'b0;
        s_config_data  = $urandom;
    endtask

    task automatic wait_sched_done(input string name);
        int w;
        w = 0;
        while (sched_done !== 1'b1 && w < 600) begin
            @(negedge clk);
            w++;
        end
        vectors++;
        if (sched_done !== 1'b1) begin
            miscompares++;
            $display("FAIL %s sched_done_timeout got=%b exp=1", name, sched_done);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vectors++;
        if (m_weight_ready !== '0 || tile_start !== 1'b0 || tile_done !== 1'b0 ||
            sched_done !== 1'b0 || underflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_outputs got rd=%h ts=%b td=%b sd=%b uf=%b exp all 0",
                     m_weight_ready, tile_start, tile_done, sched_done, underflow_err);
        end
        vectors++;
        if (s_config_ready !== 1'b0 || status_wsched !== 4'd1) begin
            miscompares++;
            $display("FAIL reset_state got ready=%b status=%0d exp ready=0 status=1",
                     s_config_ready, status_wsched);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_config_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready got=%b exp=1", s_config_ready);
        end
    endtask

    task automatic test_burst_sequence(input int b, input int t, input int dcnt);
        int last_done, n_end, sd_cnt, sd_at, rd0_cnt, rdl_cnt;
        logic [LANES-1:0] exp_v;
        weight_dcnt  = DCNT_W'(dcnt);
        array_ready  = 1'b1;
        weight_valid = '1;
        last_done = burst_start(t - 1, b) + b - 1 + (LANES - 1) * S;
        n_end     = last_done + 8;
        sd_cnt = 0; sd_at = 0; rd0_cnt = 0; rdl_cnt = 0;
        send_cfg({8'(b - 1), 24'(t)});
        for (int n = 1; n <= n_end; n++) begin
            exp_v = exp_lanes(n, b, t);
            vectors++;
            if (m_weight_ready !== exp_v) begin
                miscompares++;
                $display("FAIL lanes b=%0d t=%0d n=%0d got=%h exp=%h", b, t, n, m_weight_ready, exp_v);
            end
            vectors++;
            if (tile_start !== exp_start(n, b, t)) begin
                miscompares++;
                $display("FAIL tile_start b=%0d n=%0d got=%b exp=%b", b, n, tile_start, exp_start(n, b, t));
            end
            vectors++;
            if (tile_done !== exp_done(n, b, t)) begin
                miscompares++;
                $display("FAIL tile_done b=%0d n=%0d got=%b exp=%b", b, n, tile_done, exp_done(n, b, t));
            end
            if (n == 1 || n == 3) begin
                vectors++;
                if (status_wsched !== ((n == 1) ? 4'd2 : 4'd3)) begin
                    miscompares++;
                    $display("FAIL status n=%0d got=%0d exp=%0d", n, status_wsched, (n == 1) ? 2 : 3);
                end
            end
            if (sched_done === 1'b1) begin
                sd_cnt++;
                sd_at = n;
            end
            if (m_weight_ready[0] === 1'b1) rd0_cnt++;
            if (m_weight_ready[LANES-1] === 1'b1) rdl_cnt++;
            @(negedge clk);
        end
        vectors++;
        if (sd_cnt != 1 || sd_at <= last_done || sd_at > last_done + 4) begin
            miscompares++;
            $display("FAIL sched_done b=%0d t=%0d got count=%0d at=%0d exp count=1 in (%0d,%0d]",
                     b, t, sd_cnt, sd_at, last_done, last_done + 4);
        end
        vectors++;
        if (rd0_cnt != b * t || rdl_cnt != b * t) begin
            miscompares++;
            $display("FAIL read_count got lane0=%0d lastlane=%0d exp=%0d", rd0_cnt, rdl_cnt, b * t);
        end
        vectors++;
        if (status_wsched !== 4'd1 || s_config_ready !== 1'b1 || underflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL end_state got status=%0d ready=%b uf=%b exp 1/1/0",
                     status_wsched, s_config_ready, underflow_err);
        end
    endtask

    task automatic test_dcnt_gate();
        int w;
        logic got;
        weight_dcnt = 10'd3;
        array_ready = 1'b1;
        send_cfg(32'h0300_0001);
        for (int n = 1; n <= 20; n++) begin
            vectors++;
            if (m_weight_ready !== '0 || status_wsched !== 4'd2) begin
                miscompares++;
                $display("FAIL dcnt_hold n=%0d got rd=%h status=%0d exp rd=0 status=2",
                         n, m_weight_ready, status_wsched);
            end
            @(negedge clk);
        end
        weight_dcnt = 10'd4;
        got = 1'b0;
        w = 0;
        while (!got && w < 5) begin
            @(negedge clk);
            w++;
            if (m_weight_ready[0] === 1'b1) got = 1'b1;
        end
        vectors++;
        if (!got || tile_start !== 1'b1) begin
            miscompares++;
            $display("FAIL dcnt_release got rd0=%b tile_start=%b after %0d cycles exp 1/1",
                     got, tile_start, w);
        end
        wait_sched_done("dcnt_gate");
    endtask

    task automatic test_array_ready();
        weight_dcnt = 10'd512;
        array_ready = 1'b0;
        send_cfg(32'h0100_0001);
        for (int n = 1; n <= 12; n++) begin
            vectors++;
            if (m_weight_ready !== '0 || status_wsched !== 4'd2) begin
                miscompares++;
                $display("FAIL ready_hold n=%0d got rd=%h status=%0d exp rd=0 status=2",
                         n, m_weight_ready, status_wsched);
            end
            @(negedge clk);
        end
        array_ready = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_weight_ready[0] !== 1'b1 || tile_start !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_release got rd0=%b ts=%b exp 1/1", m_weight_ready[0], tile_start);
        end
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (m_weight_ready[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL ready_burst_len got rd0=%b exp=0 on 3rd cycle", m_weight_ready[0]);
        end
        wait_sched_done("array_ready");
    endtask

    task automatic test_zero_tiles();
        logic any_rd;
        any_rd = 1'b0;
        send_cfg(32'h0000_0000);
        vectors++;
        if (sched_done !== 1'b0 || status_wsched !== 4'd5) begin
            miscompares++;
            $display("FAIL zero_n1 got sd=%b status=%0d exp sd=0 status=5", sched_done, status_wsched);
        end
        if (m_weight_ready !== '0) any_rd = 1'b1;
        @(negedge clk);
        vectors++;
        if (sched_done !== 1'b1 || status_wsched !== 4'd1) begin
            miscompares++;
            $display("FAIL zero_n2 got sd=%b status=%0d exp sd=1 status=1", sched_done, status_wsched);
        end
        for (int n = 0; n < 10; n++) begin
            if (m_weight_ready !== '0) any_rd = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (any_rd) begin
            miscompares++;
            $display("FAIL zero_reads got reads=1 exp=0");
        end
    endtask

    task automatic test_underflow();
        int first_bad, n_end;
        logic exp_uf;
        weight_dcnt  = 10'd512;
        array_ready  = 1'b1;
        weight_valid = '1;
        weight_valid[17] = 1'b0;
        first_bad = 3 + 17 * S;
        n_end     = 3 + 3 + (LANES - 1) * S + 8;
        send_cfg(32'h0300_0001);
        for (int n = 1; n <= n_end; n++) begin
            exp_uf = (n > first_bad);
            vectors++;
            if (underflow_err !== exp_uf) begin
                miscompares++;
                $display("FAIL underflow n=%0d got=%b exp=%b", n, underflow_err, exp_uf);
            end
            @(negedge clk);
        end
        weight_valid = '1;
        send_cfg(32'h0000_0000);
        vectors++;
        if (underflow_err !== 1'b0) begin
            miscompares++;
            $display("FAIL underflow_clear got=%b exp=0", underflow_err);
        end
        wait_sched_done("underflow");
    endtask

    task automatic test_reset_mid_issue();
        logic stray;
        weight_dcnt  = 10'd512;
        array_ready  = 1'b1;
        weight_valid = '1;
        send_cfg(32'h0700_0002);
        repeat (4) @(negedge clk);
        vectors++;
        if (m_weight_ready[0] !== 1'b1 || status_wsched !== 4'd3) begin
            miscompares++;
            $display("FAIL mid_issue_pre got rd0=%b status=%0d exp 1/3", m_weight_ready[0], status_wsched);
        end
        rst = 1'b1;
        @(negedge clk);
        vectors++;
        if (m_weight_ready !== '0 || status_wsched !== 4'd1 || tile_start !== 1'b0 ||
            tile_done !== 1'b0 || sched_done !== 1'b0 || s_config_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_issue_rst got rd=%h status=%0d ts=%b td=%b sd=%b ready=%b exp 0/1/0/0/0/0",
                     m_weight_ready, status_wsched, tile_start, tile_done, sched_done, s_config_ready);
        end
        rst = 1'b0;
        @(negedge clk);
        vectors++;
        if (s_config_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mid_issue_ready got=%b exp=1", s_config_ready);
        end
        stray = 1'b0;
        for (int n = 0; n < LANES + 8; n++) begin
            if (m_weight_ready !== '0 || tile_done !== 1'b0 || status_wsched !== 4'd1) stray = 1'b1;
            @(negedge clk);
        end
        vectors++;
        if (stray) begin
            miscompares++;
            $display("FAIL mid_issue_flush got activity=1 exp=0");
        end
    endtask

    initial begin
        int rb, rt, rdc;
        rst            = 1'b1;
        s_config_valid = 1'b0;
        s_config_data  = '0;
        weight_valid   = '1;
        weight_dcnt    = '0;
        array_ready    = 1'b0;

        test_reset();
        test_burst_sequence(4, 2, 512);
        test_burst_sequence(1, 1, 1);
        test_burst_sequence(256, 1, 256);
        for (int r = 0; r < 6; r++) begin
            rb  = $urandom_range(1, 6);
            rt  = $urandom_range(1, 3);
            rdc = $urandom_range(rb, 1023);
            test_burst_sequence(rb, rt, rdc);
        end
        test_dcnt_gate();
        test_array_ready();
        test_zero_tiles();
        test_underflow();
        test_reset_mid_issue();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
